// File: rtl/half_vector_replay_loader_if.sv
// Bundles the collect/replay handshake between a half-precision result source,
// the replay loader and the downstream vector register.
// master drives collect/control inputs; slave is the loader itself.
interface half_vector_replay_loader_if #(
    parameter int BITS   = 16,
    parameter int LENGTH = 10
);
    localparam int CNT_W = $clog2(LENGTH) + 1;

    logic             clear;
    logic             in_valid;
    logic [BITS-1:0]  in_data;
    logic             start;
    logic             load_a;
    logic [BITS-1:0]  vector_a_out;
    logic             done;
    logic             full;
    logic             overflow;
    logic [CNT_W-1:0] fill_count;

    modport master (
        output clear, in_valid, in_data, start,
        input  load_a, vector_a_out, done, full, overflow, fill_count
    );

    modport slave (
        input  clear, in_valid, in_data, start,
        output load_a, vector_a_out, done, full, overflow, fill_count
    );
endinterface

// File: rtl/half_vector_replay_loader.sv
// Collects LENGTH elements, then replays them last-first as a load_a shift stream.
// Latency: first replay beat one cycle after start (or after the last accept with AUTO_START).
// No backpressure: in_valid outside COLLECT is dropped and flagged in sticky overflow.
module half_vector_replay_loader #(
    parameter int BITS       = 16,
    parameter int LENGTH     = 10,
    parameter int AUTO_START = 0
) (
    input  logic clk,
    input  logic rst,
    half_vector_replay_loader_if.slave bus
);
    localparam int PTR_W = $clog2(LENGTH) + 1;
    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LENGTH - 1);
    localparam logic [PTR_W-1:0] PTR_LEN  = PTR_W'(LENGTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FULL    = 2'd1,
        S_REPLAY  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] fill_count_q, fill_count_d;
    logic             load_a_q, load_a_d;
    logic [BITS-1:0]  vec_out_q, vec_out_d;
    logic             done_q, done_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;

    logic [BITS-1:0]  buf_q [LENGTH];
    logic             buf_we;
    logic [IDX_W-1:0] buf_waddr;
    logic [PTR_W-1:0] rd_next;

    // Next-state and registered-output computation; clear overrides everything.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_count_d = fill_count_q;
        load_a_d     = 1'b0;
        vec_out_d    = vec_out_q;
        done_d       = 1'b0;
        full_d       = full_q;
        overflow_d   = overflow_q;
        buf_we       = 1'b0;
        buf_waddr    = wr_ptr_q[IDX_W-1:0];
        rd_next      = rd_ptr_q - PTR_ONE;

        if (bus.clear) begin
            state_d      = S_COLLECT;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fill_count_d = '0;
            full_d       = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (bus.in_valid) begin
                        buf_we       = 1'b1;
                        wr_ptr_d     = wr_ptr_q + PTR_ONE;
                        fill_count_d = fill_count_q + PTR_ONE;
                        if (wr_ptr_q == PTR_LAST) begin
                            wr_ptr_d = PTR_LEN;
                            if (AUTO_START != 0) begin
                                // Last element is still on in_data; forward it as beat 0.
                                state_d      = S_REPLAY;
                                load_a_d     = 1'b1;
                                vec_out_d    = bus.in_data;
                                rd_ptr_d     = PTR_LAST;
                                fill_count_d = PTR_LAST;
                            end else begin
                                state_d = S_FULL;
                                full_d  = 1'b1;
                            end
                        end
                    end
                end
                S_FULL: begin
                    if (bus.in_valid) begin
                        overflow_d = 1'b1;
                    end
                    if (bus.start) begin
                        state_d      = S_REPLAY;
                        full_d       = 1'b0;
                        load_a_d     = 1'b1;
                        vec_out_d    = buf_q[PTR_LAST[IDX_W-1:0]];
                        rd_ptr_d     = PTR_LAST;
                        fill_count_d = PTR_LAST;
                    end
                end
                S_REPLAY: begin
                    if (bus.in_valid) begin
                        overflow_d = 1'b1;
                    end
                    // rd_ptr_q is the element currently on vector_a_out.
                    if (rd_ptr_q != '0) begin
                        load_a_d     = 1'b1;
                        vec_out_d    = buf_q[rd_next[IDX_W-1:0]];
                        rd_ptr_d     = rd_next;
                        fill_count_d = fill_count_q - PTR_ONE;
                        done_d       = (rd_next == '0);
                    end else begin
                        state_d      = S_COLLECT;
                        wr_ptr_d     = '0;
                        rd_ptr_d     = '0;
                        fill_count_d = '0;
                    end
                end
                default: begin
                    state_d      = S_COLLECT;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    fill_count_d = '0;
                    full_d       = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers, async reset drops load_a immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_count_q <= '0;
            load_a_q     <= 1'b0;
            vec_out_q    <= '0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_count_q <= fill_count_d;
            load_a_q     <= load_a_d;
            vec_out_q    <= vec_out_d;
            done_q       <= done_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
        end
    end

    // Element storage; contents are only meaningful once written, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_waddr] <= bus.in_data;
        end
    end

    assign bus.load_a       = load_a_q;
    assign bus.vector_a_out = vec_out_q;
    assign bus.done         = done_q;
    assign bus.full         = full_q;
    assign bus.overflow     = overflow_q;
    assign bus.fill_count   = fill_count_q;
endmodule

// File: tb/tb_half_vector_replay_loader.sv
// Directed bench for the replay loader: manual-start and auto-start instances,
// a downstream shift-register model, overflow, clear and async reset cases.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled there too.
module tb_half_vector_replay_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    half_vector_replay_loader_if #(.BITS(16), .LENGTH(10)) ifa ();
    half_vector_replay_loader_if #(.BITS(16), .LENGTH(10)) ifb ();

    half_vector_replay_loader #(.BITS(16), .LENGTH(10), .AUTO_START(0)) u_man (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    half_vector_replay_loader #(.BITS(16), .LENGTH(10), .AUTO_START(1)) u_auto (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Downstream vector register: shifts in at index 0, so the first beat ends at index 9.
    logic [15:0] vreg [10];
    always @(posedge clk) begin
        if (ifa.load_a) begin
            for (int j = 9; j > 0; j--) vreg[j] <= vreg[j-1];
            vreg[0] <= ifa.vector_a_out;
        end
    end

    logic b_seen_full = 1'b0;
    always @(posedge clk) begin
        if (ifb.full) b_seen_full <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Ten accepts of base+i with idle gaps sprinkled in; ends right after the 10th accept.
    task automatic fill_a(input logic [15:0] base);
        for (int i = 0; i < 10; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 16'(base + 16'(i));
            step();
            ifa.in_valid = 1'b0;
            if (i % 3 == 1) step();
        end
    endtask

    // Called right after the start edge: expects base+9 .. base+0 on consecutive cycles.
    task automatic replay_a(input logic [15:0] base);
        for (int k = 0; k < 10; k++) begin
            chk("rep_load", 32'(ifa.load_a), 32'd1);
            chk("rep_data", 32'(ifa.vector_a_out), 32'(16'(base + 16'(9 - k))));
            chk("rep_done", 32'(ifa.done), (k == 9) ? 32'd1 : 32'd0);
            step();
        end
        chk("post_load", 32'(ifa.load_a), 32'd0);
        chk("post_done", 32'(ifa.done), 32'd0);
        chk("post_hold", 32'(ifa.vector_a_out), 32'(base));
        chk("post_fill", 32'(ifa.fill_count), 32'd0);
        // Vector-add with b = 0: each sum equals the loaded element.
        for (int i = 0; i < 10; i++) begin
            chk("vec_sum", 32'(16'(vreg[i] + 16'h0000)), 32'(16'(base + 16'(i))));
        end
    endtask

    initial begin
        ifa.clear = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.start = 1'b0;
        ifb.clear = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.start = 1'b0;

        // Reset asserted mid-cycle: outputs zero without waiting for a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_load", 32'(ifa.load_a), 32'd0);
        chk("rst_data", 32'(ifa.vector_a_out), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_full", 32'(ifa.full), 32'd0);
        chk("rst_ovf", 32'(ifa.overflow), 32'd0);
        chk("rst_fill", 32'(ifa.fill_count), 32'd0);
        @(negedge clk) rst = 1'b0;
        step();
        chk("rel_fill", 32'(ifa.fill_count), 32'd0);

        // Basic fill and manual replay.
        fill_a(16'h3C00);
        chk("full_set", 32'(ifa.full), 32'd1);
        chk("full_cnt", 32'(ifa.fill_count), 32'd10);
        chk("full_noload", 32'(ifa.load_a), 32'd0);
        step();
        chk("full_hold", 32'(ifa.full), 32'd1);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        chk("start_full", 32'(ifa.full), 32'd0);
        replay_a(16'h3C00);

        // start in COLLECT is ignored.
        ifa.in_valid = 1'b1; ifa.in_data = 16'h1234;
        step();
        ifa.in_valid = 1'b0; ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        chk("ign_load", 32'(ifa.load_a), 32'd0);
        chk("ign_fill", 32'(ifa.fill_count), 32'd1);
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        chk("clr_fill", 32'(ifa.fill_count), 32'd0);

        // Overflow while FULL: sample dropped, replay unchanged.
        fill_a(16'h4000);
        ifa.in_valid = 1'b1; ifa.in_data = 16'hFFFF;
        step();
        ifa.in_valid = 1'b0;
        chk("ovf_full", 32'(ifa.overflow), 32'd1);
        chk("ovf_cnt", 32'(ifa.fill_count), 32'd10);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        replay_a(16'h4000);
        chk("ovf_sticky", 32'(ifa.overflow), 32'd1);
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        chk("ovf_clr", 32'(ifa.overflow), 32'd0);
        chk("ovf_clr_fill", 32'(ifa.fill_count), 32'd0);

        // in_valid on the done beat still counts as REPLAY; the next cycle accepts.
        fill_a(16'h4100);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("edge_done", 32'(ifa.done), 32'd1);
        ifa.in_valid = 1'b1; ifa.in_data = 16'hFFFF;
        step();
        chk("edge_ovf", 32'(ifa.overflow), 32'd1);
        chk("edge_fill", 32'(ifa.fill_count), 32'd0);
        chk("edge_load", 32'(ifa.load_a), 32'd0);
        ifa.in_data = 16'h4242;
        step();
        ifa.in_valid = 1'b0;
        chk("edge_accept", 32'(ifa.fill_count), 32'd1);
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        chk("edge_clr", 32'(ifa.overflow), 32'd0);

        // clear on the 4th replay beat aborts; a fresh fill then replays correctly.
        fill_a(16'h4500);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("abort_beat4", 32'(ifa.vector_a_out), 32'h4506);
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        chk("abort_load", 32'(ifa.load_a), 32'd0);
        chk("abort_fill", 32'(ifa.fill_count), 32'd0);
        chk("abort_full", 32'(ifa.full), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_nodone", 32'(ifa.done), 32'd0);
            step();
        end
        fill_a(16'h4800);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        replay_a(16'h4800);

        // Auto-start instance: replay follows the 10th accept directly.
        for (int i = 0; i < 10; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = 16'(16'h6000 + 16'(i));
            step();
        end
        ifb.in_valid = 1'b0;
        chk("auto_load", 32'(ifb.load_a), 32'd1);
        chk("auto_first", 32'(ifb.vector_a_out), 32'h6009);
        chk("auto_full", 32'(ifb.full), 32'd0);
        for (int k = 1; k < 10; k++) begin
            step();
            chk("auto_data", 32'(ifb.vector_a_out), 32'(16'(16'h6009 - 16'(k))));
            chk("auto_done", 32'(ifb.done), (k == 9) ? 32'd1 : 32'd0);
        end
        step();
        chk("auto_end", 32'(ifb.load_a), 32'd0);
        chk("auto_never_full", 32'(b_seen_full), 32'd0);

        // Reset mid-replay with overflow set drops everything immediately.
        fill_a(16'h4A00);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_data = 16'hFFFF;
        step();
        ifa.in_valid = 1'b0;
        chk("mid_ovf", 32'(ifa.overflow), 32'd1);
        chk("mid_load", 32'(ifa.load_a), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("mrst_load", 32'(ifa.load_a), 32'd0);
        chk("mrst_data", 32'(ifa.vector_a_out), 32'd0);
        chk("mrst_ovf", 32'(ifa.overflow), 32'd0);
        chk("mrst_fill", 32'(ifa.fill_count), 32'd0);
        @(negedge clk) rst = 1'b0;
        step();
        chk("mrst_after", 32'(ifa.load_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
